key_debounce_multi: RTL and testbench
=====================================

// Module: key_debounce_multi
// PURPOSE
//  N-channel key conditioner; one generic instance serves every front-panel key of the DDS generator.
//  Per channel: 2-FF synchroniser, debounced level, and 1-cycle press/release pulses.
//  Also a one-shot long-press pulse and an optional auto-repeat pulse train.
//  Feeds the waveform/frequency/amplitude control FSMs, which consume single-cycle pulses only.
// PARAMETERS
//  N_KEYS        4           number of independent key channels (>=1)
//  ACTIVE_LOW    1           1: key_in low = pressed; 0: key_in high = pressed
//  DB_CYCLES     1_000_000   consecutive stable cycles to accept a level change (20 ms @ 50 MHz); >=2
//  LONG_CYCLES   50_000_000  cycles held after key_press until key_long fires (1 s); > DB_CYCLES
//  REPEAT_CYCLES 5_000_000   auto-repeat period after key_long (100 ms); >=2
// PORTS
//  clk          in   1       system clock, one clock domain
//  rst          in   1       asynchronous, active-high reset; one clock, no other reset
//  key_in       in   N_KEYS  raw asynchronous key pins
//  key_state    out  N_KEYS  debounced level, 1 = pressed
//  key_press    out  N_KEYS  1-cycle pulse on debounced press
//  key_release  out  N_KEYS  1-cycle pulse on debounced release
//  key_long     out  N_KEYS  1-cycle pulse, once per press, LONG_CYCLES after key_press
//  key_repeat   out  N_KEYS  1-cycle auto-repeat pulses; constant 0 when KEY_REPEAT_EN is undefined
// BEHAVIOUR
//  Reset: all outputs 0, all counters 0, sync FFs and debounced state = released level.
//  A key held through reset therefore yields a normal key_press after debounce.
//  Sync: key_in is normalised by ACTIVE_LOW, then 2 FFs give the synchronised level s.
//  Debounce, per channel (counter db_cnt, width $clog2(DB_CYCLES+1)):
//   - s == key_state: db_cnt <= 0.
//   - s != key_state: db_cnt increments.
//   - When db_cnt == DB_CYCLES-1 with mismatch still present: key_state flips and db_cnt <= 0.
//     The matching key_press or key_release is registered at the same edge.
//   - Any return to agreement before that point clears db_cnt. No partial credit.
//  Latency: for a clean edge, key_press/key_release is high in cycle DB_CYCLES+2.
//   Cycle count starts at the first clk edge that samples the new key_in level.
//  Hold FSM, per channel: IDLE -> HELD -> LONG.
//   - IDLE: on key_press go to HELD, hold_cnt <= 0.
//   - HELD: hold_cnt increments. At hold_cnt == LONG_CYCLES-1: key_long pulse, go to LONG, rep_cnt <= 0.
//   - LONG: no further key_long until a new press.
//   - Any state: key_release forces IDLE, clears hold_cnt and rep_cnt. Release has priority over same-cycle long/repeat.
//  Outputs key_press, key_release, key_long and key_repeat are registered.
//   They are mutually exclusive per channel per cycle.
//  Channels are fully independent. Simultaneous events on different channels all pulse in the same cycle.
//  Counters saturate and never wrap. hold_cnt width is $clog2(LONG_CYCLES), rep_cnt width is $clog2(REPEAT_CYCLES).
//  rst asserted mid-operation: everything returns to reset values immediately (async). No pulse is emitted on exit.
// CONFIGURATION
//  KEY_REPEAT_EN defined:
//   - In LONG, rep_cnt counts. At REPEAT_CYCLES-1: key_repeat pulse, rep_cnt <= 0.
//   - First repeat comes REPEAT_CYCLES after key_long, then periodic while the key stays held.
//  KEY_REPEAT_EN undefined: no rep_cnt logic; key_repeat tied to 0. Port list unchanged.
// STRUCTURE
//  Package key_debounce_pkg:
//   - hold-state enum (IDLE/HELD/LONG)
//   - default cycle constants for 50 MHz (20 ms, 1 s, 100 ms)
//  Sub-module key_debounce_chan: one channel (sync, debounce, hold FSM, optional repeat).
//   Instantiated N_KEYS times by a generate loop in key_debounce_multi. Top level is wiring only.
// TESTING (N_KEYS=4, ACTIVE_LOW=1, DB_CYCLES=8, LONG_CYCLES=40, REPEAT_CYCLES=10)
//  1 Bounce: key_in[0] toggles every 3 cycles for 30 cycles, then stays low.
//    -> exactly one key_press[0], in cycle 10 after the last edge; no key_release; key_state[0]=1.
//  2 Glitch: key_in[1] low for 7 cycles, then high.
//    -> no pulses; key_state[1] stays 0.
//  3 Long hold: key_in[2] low for 100 cycles, then high.
//    -> key_press; key_long 40 cycles later.
//    -> with KEY_REPEAT_EN: key_repeat at +10, +20, ... until release; without it: never.
//    -> key_release in cycle 10 after the rising edge.
//  4 Simultaneous: key_in[0] and key_in[3] fall on the same edge.
//    -> key_press[0] and key_press[3] high in the same cycle; other channels quiet.
//  5 Reset mid-hold: rst pulsed for 2 cycles when hold_cnt=30; key still low.
//    -> all outputs 0 during reset; no key_release; new key_press 10 cycles after rst deasserts; key_long 40 cycles after that.
//  6 Release on long edge: release timed so debounce completes in the same cycle key_long would fire.
//    -> key_release only; no key_long.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and default timing constants for the front-panel key conditioner.
// Default constants assume a 50 MHz system clock.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } hold_state_e;

   localparam int unsigned DB_CYCLES_DEF     = 32'd1_000_000;   // 20 ms
   localparam int unsigned LONG_CYCLES_DEF   = 32'd50_000_000;  // 1 s
   localparam int unsigned REPEAT_CYCLES_DEF = 32'd5_000_000;   // 100 ms

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchroniser, debounce, press/release pulses and long-press FSM.
// Auto-repeat pulses exist only when KEY_REPEAT_EN is defined; otherwise key_repeat is tied low.
module key_debounce_chan
   import key_debounce_pkg::*;
#(
   parameter int unsigned ACTIVE_LOW    = 32'd1,
   parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
   parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_state,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_repeat
);

   localparam int unsigned DB_W   = $clog2(DB_CYCLES + 32'd1);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 32'd1);
   localparam logic [DB_W-1:0]   DB_MAX    = {DB_W{1'b1}};
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};
`ifdef KEY_REPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 32'd1);
   localparam logic [REP_W-1:0] REP_MAX  = {REP_W{1'b1}};
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             repeat_q, repeat_d;
`endif

   logic              key_lvl;
   logic [1:0]        sync_q, sync_d;
   logic              key_state_q, key_state_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;
   hold_state_e       hold_st_q, hold_st_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   // Pressed level is always 1 after normalisation.
   assign key_lvl = (ACTIVE_LOW != 32'd0) ? ~key_raw : key_raw;

   // Next-state: synchroniser shift, debounce counter, hold FSM and pulse generation.
   always_comb begin
      sync_d      = {sync_q[0], key_lvl};
      key_state_d = key_state_q;
      db_cnt_d    = db_cnt_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      hold_st_d   = hold_st_q;
      hold_cnt_d  = hold_cnt_q;
`ifdef KEY_REPEAT_EN
      rep_cnt_d   = rep_cnt_q;
      repeat_d    = 1'b0;
`endif

      if (sync_q[1] == key_state_q) begin
         db_cnt_d = {DB_W{1'b0}};
      end else if (db_cnt_q == DB_LAST) begin
         key_state_d = sync_q[1];
         db_cnt_d    = {DB_W{1'b0}};
         press_d     = sync_q[1];
         release_d   = ~sync_q[1];
      end else if (db_cnt_q != DB_MAX) begin
         db_cnt_d = db_cnt_q + DB_W'(1'b1);
      end else begin
         db_cnt_d = db_cnt_q;
      end

      // A release in the same cycle wins over a pending long or repeat pulse.
      if (release_d) begin
         hold_st_d  = IDLE;
         hold_cnt_d = {HOLD_W{1'b0}};
`ifdef KEY_REPEAT_EN
         rep_cnt_d  = {REP_W{1'b0}};
`endif
      end else begin
         case (hold_st_q)
            IDLE: begin
               if (press_d) begin
                  hold_st_d  = HELD;
                  hold_cnt_d = {HOLD_W{1'b0}};
               end else begin
                  hold_st_d  = IDLE;
               end
            end
            HELD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  long_d    = 1'b1;
                  hold_st_d = LONG;
`ifdef KEY_REPEAT_EN
                  rep_cnt_d = {REP_W{1'b0}};
`endif
               end else if (hold_cnt_q != HOLD_MAX) begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1'b1);
               end else begin
                  hold_cnt_d = hold_cnt_q;
               end
            end
            LONG: begin
`ifdef KEY_REPEAT_EN
               if (rep_cnt_q == REP_LAST) begin
                  repeat_d  = 1'b1;
                  rep_cnt_d = {REP_W{1'b0}};
               end else if (rep_cnt_q != REP_MAX) begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1'b1);
               end else begin
                  rep_cnt_d = rep_cnt_q;
               end
`else
               hold_st_d = LONG;
`endif
            end
            default: begin
               hold_st_d  = IDLE;
               hold_cnt_d = {HOLD_W{1'b0}};
            end
         endcase
      end
   end

   // State and output registers, cleared asynchronously to the released level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q      <= 2'b00;
         key_state_q <= 1'b0;
         db_cnt_q    <= {DB_W{1'b0}};
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         hold_st_q   <= IDLE;
         hold_cnt_q  <= {HOLD_W{1'b0}};
`ifdef KEY_REPEAT_EN
         rep_cnt_q   <= {REP_W{1'b0}};
         repeat_q    <= 1'b0;
`endif
      end else begin
         sync_q      <= sync_d;
         key_state_q <= key_state_d;
         db_cnt_q    <= db_cnt_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
         hold_st_q   <= hold_st_d;
         hold_cnt_q  <= hold_cnt_d;
`ifdef KEY_REPEAT_EN
         rep_cnt_q   <= rep_cnt_d;
         repeat_q    <= repeat_d;
`endif
      end
   end

   assign key_state   = key_state_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_long    = long_q;
`ifdef KEY_REPEAT_EN
   assign key_repeat  = repeat_q;
`else
   assign key_repeat  = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel key conditioner: one independent key_debounce_chan per key pin.
// Optional auto-repeat is enabled by defining KEY_REPEAT_EN.
module key_debounce_multi
   import key_debounce_pkg::*;
#(
   parameter int unsigned N_KEYS        = 32'd4,
   parameter int unsigned ACTIVE_LOW    = 32'd1,
   parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
   parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_KEYS-1:0] key_repeat
);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
      key_debounce_chan #(
         .ACTIVE_LOW    (ACTIVE_LOW),
         .DB_CYCLES     (DB_CYCLES),
         .LONG_CYCLES   (LONG_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .key_raw     (key_in[i]),
         .key_state   (key_state[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .key_long    (key_long[i]),
         .key_repeat  (key_repeat[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: stimulus queues expected pulses (cycle, kind, channel),
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_key_debounce_multi;

   localparam int N  = 4;
   localparam int DB = 8;
   localparam int LG = 40;
   localparam int RP = 10;

   localparam int K_PRESS   = 0;
   localparam int K_RELEASE = 1;
   localparam int K_LONG    = 2;
   localparam int K_REPEAT  = 3;

   typedef struct packed {
      int cyc;
      int kind;
      int ch;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] key_in;
   logic [N-1:0] key_state, key_press, key_release, key_long, key_repeat;

   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t exp_q[$];

   key_debounce_multi #(
      .N_KEYS        (N),
      .ACTIVE_LOW    (1),
      .DB_CYCLES     (DB),
      .LONG_CYCLES   (LG),
      .REPEAT_CYCLES (RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long),
      .key_repeat  (key_repeat)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_ev(input int c, input int k, input int ch);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.ch   = ch;
      exp_q.push_back(e);
   endtask

   task automatic check_state(input string name, input logic [N-1:0] req);
      checks++;
      if (key_state !== req) begin
         errors++;
         $display("FAIL %s: key_state %b, required %b (cycle %0d)", name, key_state, req, cyc);
      end
   endtask

   task automatic check_quiet(input string name);
      checks++;
      if ((key_state | key_press | key_release | key_long | key_repeat) !== '0) begin
         errors++;
         $display("FAIL %s: outputs st=%b pr=%b rl=%b lg=%b rp=%b, required all 0",
                  name, key_state, key_press, key_release, key_long, key_repeat);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every pulse seen must match the head of the expected queue.
   always @(negedge clk) begin
      ev_t  e;
      logic hit;
      for (int ch = 0; ch < N; ch++) begin
         for (int k = 0; k < 4; k++) begin
            case (k)
               K_PRESS:   hit = key_press[ch];
               K_RELEASE: hit = key_release[ch];
               K_LONG:    hit = key_long[ch];
               default:   hit = key_repeat[ch];
            endcase
            if (hit === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_pulse: kind %0d ch %0d cycle %0d, no pulse required", k, ch, cyc);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.kind != k || e.ch != ch) begin
                     errors++;
                     $display("FAIL pulse: got kind %0d ch %0d cycle %0d, required kind %0d ch %0d cycle %0d",
                              k, ch, cyc, e.kind, e.ch, e.cyc);
                  end
               end
            end
         end
      end
   end

   initial begin
      int c0;
      int r0;
      rst    = 1'b1;
      key_in = 4'hF;
      wait_cyc(3);
      check_state("reset_state", 4'b0000);
      check_quiet("reset_outputs");
      rst = 1'b0;
      wait_cyc(10);

      // 1: bounce on ch0, ten 3-cycle segments, then a clean fall
      for (int i = 0; i < 10; i++) begin
         key_in[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
         wait_cyc(3);
      end
      key_in[0] = 1'b0;
      expect_ev(cyc + 10, K_PRESS, 0);
      wait_cyc(20);
      check_state("bounce_state", 4'b0001);
      key_in[0] = 1'b1;
      expect_ev(cyc + 10, K_RELEASE, 0);
      wait_cyc(20);
      check_state("bounce_released", 4'b0000);

      // 2: 7-cycle glitch on ch1 must be rejected
      key_in[1] = 1'b0;
      wait_cyc(7);
      key_in[1] = 1'b1;
      wait_cyc(20);
      check_state("glitch_state", 4'b0000);

      // 3: long hold on ch2
      c0 = cyc;
      key_in[2] = 1'b0;
      expect_ev(c0 + 10, K_PRESS, 2);
      expect_ev(c0 + 50, K_LONG, 2);
`ifdef KEY_REPEAT_EN
      for (int r = 1; r <= 5; r++) expect_ev(c0 + 50 + r * RP, K_REPEAT, 2);
`endif
      wait_cyc(60);
      check_state("long_hold_state", 4'b0100);
      wait_cyc(40);
      key_in[2] = 1'b1;
      expect_ev(cyc + 10, K_RELEASE, 2);
      wait_cyc(30);
      check_state("long_hold_released", 4'b0000);

      // 4: simultaneous falls on ch0 and ch3
      c0 = cyc;
      key_in[0] = 1'b0;
      key_in[3] = 1'b0;
      expect_ev(c0 + 10, K_PRESS, 0);
      expect_ev(c0 + 10, K_PRESS, 3);
      wait_cyc(20);
      check_state("simul_state", 4'b1001);
      key_in[0] = 1'b1;
      key_in[3] = 1'b1;
      expect_ev(cyc + 10, K_RELEASE, 0);
      expect_ev(cyc + 10, K_RELEASE, 3);
      wait_cyc(20);
      check_state("simul_released", 4'b0000);

      // 5: reset pulse while ch1 is held (hold_cnt = 30)
      c0 = cyc;
      key_in[1] = 1'b0;
      expect_ev(c0 + 10, K_PRESS, 1);
      wait_cyc(40);
      rst = 1'b1;
      wait_cyc(1);
      check_quiet("rst_mid_hold_1");
      wait_cyc(1);
      check_quiet("rst_mid_hold_2");
      rst = 1'b0;
      r0 = cyc;
      expect_ev(r0 + 10, K_PRESS, 1);
      expect_ev(r0 + 50, K_LONG, 1);
`ifdef KEY_REPEAT_EN
      expect_ev(r0 + 60, K_REPEAT, 1);
`endif
      wait_cyc(20);
      check_state("rst_repress_state", 4'b0010);
      wait_cyc(35);
      key_in[1] = 1'b1;
      expect_ev(cyc + 10, K_RELEASE, 1);
      wait_cyc(20);
      check_state("rst_released", 4'b0000);

      // 6: release debounce lands on the cycle key_long would fire
      c0 = cyc;
      key_in[3] = 1'b0;
      expect_ev(c0 + 10, K_PRESS, 3);
      wait_cyc(40);
      key_in[3] = 1'b1;
      expect_ev(c0 + 50, K_RELEASE, 3);
      wait_cyc(30);
      check_state("long_edge_released", 4'b0000);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_pulses: %0d still queued (first kind %0d ch %0d cycle %0d), required 0",
                  exp_q.size(), exp_q[0].kind, exp_q[0].ch, exp_q[0].cyc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
